// File: rtl/rr_address_arbiter.sv
// Round-robin arbiter feeding a demux: one grant at a time, held until ack,
// withdrawal or hold timeout, with a mandatory idle bubble between grants.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no grant; pick next requester starting at ptr
// S_GRANT | grant held; release on ack, withdrawal or hold timeout
module rr_address_arbiter #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int MAX_HOLD      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [(1<<ADDRESS_WIDTH)-1:0] i_req,
  input  logic                          i_ack,
  output logic [ADDRESS_WIDTH-1:0]      o_add,
  output logic                          o_x,
  output logic [(1<<ADDRESS_WIDTH)-1:0] o_gnt,
  output logic                          o_timeout
);

  localparam int N  = 1 << ADDRESS_WIDTH;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] add_q, add_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [N-1:0]             gnt_q, gnt_d;
  logic                     x_q, x_d;
  logic                     timeout_q, timeout_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic [ADDRESS_WIDTH-1:0] sel;
  logic                     found;
  logic                     release_grant;

  // Rotating priority search; the index naturally wraps modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[ptr_q + ADDRESS_WIDTH'(i)]) begin
        sel   = ptr_q + ADDRESS_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    add_d         = add_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    x_d           = x_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          add_d   = sel;
          gnt_d   = N'(1) << sel;
          x_d     = 1'b1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (i_ack) begin
          release_grant = 1'b1;
        end else if (!i_req[add_q]) begin
          release_grant = 1'b1;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
          release_grant = 1'b1;
          timeout_d     = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // o_add keeps its last value across release so the demux address is stable.
    if (release_grant) begin
      x_d     = 1'b0;
      gnt_d   = '0;
      ptr_d   = add_q + 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      add_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      x_q       <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      add_q     <= add_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_add     = add_q;
  assign o_x       = x_q;
  assign o_gnt     = gnt_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_address_arbiter.sv
// Directed bench for rr_address_arbiter (ADDRESS_WIDTH=2, MAX_HOLD=4); observed
// bundle is {o_x, o_add, o_gnt, o_timeout}, sampled 1ns after each rising edge.
module tb_rr_address_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_req = '0;
  logic       i_ack = 1'b0;
  logic [1:0] o_add;
  logic       o_x;
  logic [3:0] o_gnt;
  logic       o_timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_address_arbiter #(.ADDRESS_WIDTH(2), .MAX_HOLD(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_ack     (i_ack),
    .o_add     (o_add),
    .o_x       (o_x),
    .o_gnt     (o_gnt),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got time-limit expiry want normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = 4'b1111; i_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_00_0000_0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b want %b", c, {o_x, o_add, o_gnt, o_timeout}, 8'b0_00_0000_0);
      end
    end
    i_rst = 1'b0; i_ack = 1'b0;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b1_00_0001_0) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b1_00_0001_0);
    end
    i_req = 4'b0000;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_00_0000_0) begin
      n_err++;
      $display("FAIL reset_withdraw: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b0_00_0000_0);
    end
  endtask

  task automatic test_single_grant();
    i_req = 4'b0100;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b1_10_0100_0) begin
      n_err++;
      $display("FAIL single_grant: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b1_10_0100_0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({o_x, o_add, o_gnt, o_timeout} !== 8'b1_10_0100_0) begin
        n_err++;
        $display("FAIL single_hold[%0d]: got %b want %b", c, {o_x, o_add, o_gnt, o_timeout}, 8'b1_10_0100_0);
      end
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0; i_req = 4'b0000;
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_10_0000_0) begin
      n_err++;
      $display("FAIL single_ack_release: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b0_10_0000_0);
    end
  endtask

  task automatic test_fairness();
    int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
    logic [1:0] ea;
    apply_reset();
    i_req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      ea = 2'(exp_seq[k]);
      tick();
      n_cmp++;
      if ({o_x, o_add, o_gnt} !== {1'b1, ea, 4'(4'b0001 << ea)}) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: got x=%b add=%0d gnt=%b want x=1 add=%0d gnt=%b",
                 k, o_x, o_add, o_gnt, ea, 4'(4'b0001 << ea));
      end
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
      n_cmp++;
      if ({o_x, o_gnt} !== 5'b0_0000) begin
        n_err++;
        $display("FAIL fair_bubble[%0d]: got x=%b gnt=%b want x=0 gnt=0000", k, o_x, o_gnt);
      end
    end
  endtask

  task automatic test_wrap();
    i_req = 4'b1001;
    tick();
    n_cmp++;
    if ({o_x, o_add} !== 3'b1_00) begin
      n_err++;
      $display("FAIL wrap_to_0: got x=%b add=%0d want x=1 add=0", o_x, o_add);
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt} !== 7'b1_11_1000) begin
      n_err++;
      $display("FAIL wrap_next_3: got x=%b add=%0d gnt=%b want x=1 add=3 gnt=1000", o_x, o_add, o_gnt);
    end
    i_ack = 1'b1; i_req = 4'b0000;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic test_timeout();
    i_req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({o_x, o_add, o_gnt, o_timeout} !== 8'b1_01_0010_0) begin
        n_err++;
        $display("FAIL timeout_hold[%0d]: got %b want %b", c, {o_x, o_add, o_gnt, o_timeout}, 8'b1_01_0010_0);
      end
    end
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_01_0000_1) begin
      n_err++;
      $display("FAIL timeout_pulse: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b0_01_0000_1);
    end
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b1_01_0010_0) begin
      n_err++;
      $display("FAIL timeout_regrant: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b1_01_0010_0);
    end
    // ack coinciding with the timeout edge wins and suppresses the pulse
    for (int c = 0; c < 3; c++) tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0; i_req = 4'b0000;
    n_cmp++;
    if ({o_x, o_timeout} !== 2'b00) begin
      n_err++;
      $display("FAIL ack_vs_timeout: got x=%b timeout=%b want x=0 timeout=0", o_x, o_timeout);
    end
    tick();
    n_cmp++;
    if (o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL ack_vs_timeout_late: got timeout=%b want 0", o_timeout);
    end
  endtask

  task automatic test_withdrawal();
    i_req = 4'b0100;
    tick();
    tick();
    n_cmp++;
    if ({o_x, o_add} !== 3'b1_10) begin
      n_err++;
      $display("FAIL withdraw_grant: got x=%b add=%0d want x=1 add=2", o_x, o_add);
    end
    i_req = 4'b0000;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_10_0000_0) begin
      n_err++;
      $display("FAIL withdraw_release: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b0_10_0000_0);
    end
  endtask

  task automatic test_reset_mid_grant();
    i_req = 4'b0010;
    tick();
    n_cmp++;
    if ({o_x, o_add} !== 3'b1_01) begin
      n_err++;
      $display("FAIL midrst_grant: got x=%b add=%0d want x=1 add=1", o_x, o_add);
    end
    i_rst = 1'b1; i_ack = 1'b1;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt, o_timeout} !== 8'b0_00_0000_0) begin
      n_err++;
      $display("FAIL midrst_clear: got %b want %b", {o_x, o_add, o_gnt, o_timeout}, 8'b0_00_0000_0);
    end
    i_rst = 1'b0; i_ack = 1'b0; i_req = 4'b1111;
    tick();
    n_cmp++;
    if ({o_x, o_add, o_gnt} !== 7'b1_00_0001) begin
      n_err++;
      $display("FAIL midrst_ptr0: got x=%b add=%0d gnt=%b want x=1 add=0 gnt=0001", o_x, o_add, o_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fairness();
    test_wrap();
    test_timeout();
    test_withdrawal();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
